spi_cfg_controller: RTL and testbench

- SPI controller that serialises register-write requests into 16-bit frames for the `spi_peripheral` configuration register file (output enables, PWM enables, PWM duty).
- Requesters (reset-time init sequencer, test/debug logic) hand it `{write, addr, data}` over a valid/ready handshake.
- It drives `nCS`, `SCLK` and `COPI` in SPI mode 0, MSB first.
- It rejects writes to addresses beyond the register file.

---
 rtl/spi_cfg_controller.sv | 197 +++++++++++++++++++
 tb/tb_spi_cfg_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_controller.sv
// -----------------------------------------------------------------------------
// spi_cfg_controller
//
// Serialises register requests {write, addr[6:0], data[7:0]} into 16-bit SPI
// mode-0 frames (MSB first) for the spi_peripheral configuration register file.
// Writes addressed above MAX_ADDR are rejected with a one-cycle err pulse and
// no frame.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_write             1 = write frame, 0 = read/address-only frame
//   req_addr, req_data    register address and write data
//   SCLK, COPI, nCS       SPI pins (all registered)
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse as nCS rises at frame end
//   err                   one-cycle pulse on a rejected request
// -----------------------------------------------------------------------------
module spi_cfg_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4,
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int PH_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CMAX1 = (CMAX0 > CS_GAP) ? CMAX0 : CS_GAP;
    localparam int CMAX  = (CMAX1 > 1) ? CMAX1 : 1;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    // A zero-length setup/hold/gap still costs one transition cycle.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((CS_GAP   > 0) ? CS_GAP   - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CMAX);
    localparam logic [6:0]       ADDR_MAX   = 7'(MAX_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_REJECT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      shreg_q, shreg_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic             copi_q, copi_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Shared state counter never wraps.
        cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_write && (req_addr > ADDR_MAX)) begin
                        state_d = S_REJECT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        shreg_d = {req_write, req_addr, req_data};
                        ncs_d   = 1'b0;
                        copi_d  = req_write;
                        cnt_d   = '0;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    phase_d = '0;
                    bit_d   = 4'd15;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SHIFT: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + PH_W'(1);
                end else begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: the only point where COPI may change.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end else begin
                            shreg_d = shreg_q << 1;
                            bit_d   = bit_q - 4'd1;
                            copi_d  = shreg_q[14];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_REJECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_controller
//
// Directed bench for spi_cfg_controller with default parameters. A negedge
// monitor decodes the SPI pins into frames and feeds a small model of the
// peripheral's five configuration registers.
// -----------------------------------------------------------------------------
module tb_spi_cfg_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       SCLK, COPI, nCS, busy, done, err;

    always #5 clk = ~clk;

    spi_cfg_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    logic        sclk_p = 1'b0, ncs_p = 1'b1, copi_p = 1'b0;
    int          low_len = 0, high_len = 0, last_low = 0, last_high = 0;
    int          rise_cnt = 0, total_rise = 0, frames = 0;
    int          done_cnt = 0, err_cnt = 0, err_cyc = 0, viol = 0, done_bad = 0;
    logic [15:0] rx = '0;
    logic [15:0] last_rx = '0;
    logic [7:0]  regs [0:4];

    initial begin
        int a;
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (SCLK === 1'b1 && sclk_p === 1'b0) begin
                rx = {rx[14:0], COPI};
                rise_cnt++;
                total_rise++;
            end
            if (SCLK === 1'b1 && sclk_p === 1'b1 && COPI !== copi_p) viol++;
            if (nCS === 1'b0) begin
                if (ncs_p === 1'b1) begin
                    last_high = high_len;
                    low_len   = 0;
                    frames++;
                end
                low_len++;
            end else if (nCS === 1'b1) begin
                if (ncs_p === 1'b0) begin
                    last_low = low_len;
                    high_len = 0;
                    last_rx  = rx;
                    a = int'(rx[14:8]);
                    if (rise_cnt == 16 && rx[15] && a <= 4) regs[a] = rx[7:0];
                    rise_cnt = 0;
                    rx = '0;
                end
                high_len++;
                if (SCLK !== 1'b0 || COPI !== 1'b0) viol++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (!(nCS === 1'b1 && ncs_p === 1'b0)) done_bad++;
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            sclk_p = SCLK;
            ncs_p  = nCS;
            copi_p = COPI;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Present a request and return the cycle index of the accepting cycle.
    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
        int k = 0;
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", req_ready, 1'b1);
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Fields are latched; scribble over them.
        req_write = ~w;
        req_addr  = 7'h7F;
        req_data  = ~d;
    endtask

    task automatic wait_ready(output int when);
        int k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("ready_in_time", req_ready, 1'b1);
        when = cyc;
    endtask

    initial begin
        int acc, acc2, rdy, f0, r0, d0, e0, k;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        #1 rst_n = 1'b0;
        #32;
        chk("rst_ncs", nCS, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_copi", COPI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write addr 4 <- 0xA5
        d0 = done_cnt; e0 = err_cnt;
        send(1'b1, 7'd4, 8'hA5, acc);
        @(negedge clk);
        chk("busy_after_accept", busy, 1'b1);
        wait_ready(rdy);
        chk("w4_ready_latency", rdy - acc, 137);
        chk("w4_ncs_low_len", last_low, 132);
        chk("w4_word", last_rx, 16'h84A5);
        chk("w4_done_count", done_cnt - d0, 1);
        chk("w4_no_err", err_cnt - e0, 0);
        chk("w4_reg4", regs[4], 8'hA5);

        // Out-of-range write: addr 5
        f0 = frames; r0 = total_rise; d0 = done_cnt; e0 = err_cnt;
        send(1'b1, 7'd5, 8'h12, acc);
        wait_ready(rdy);
        chk("rej_ready_latency", rdy - acc, 2);
        chk("rej_err_count", err_cnt - e0, 1);
        chk("rej_err_cycle", err_cyc - acc, 1);
        chk("rej_no_frame", frames - f0, 0);
        chk("rej_no_sclk", total_rise - r0, 0);
        chk("rej_no_done", done_cnt - d0, 0);

        // Read frame addr 7 (not range-checked)
        e0 = err_cnt; d0 = done_cnt;
        send(1'b0, 7'd7, 8'h3C, acc);
        wait_ready(rdy);
        chk("rd_word", last_rx, 16'h073C);
        chk("rd_no_err", err_cnt - e0, 0);
        chk("rd_done", done_cnt - d0, 1);
        chk("rd_latency", rdy - acc, 137);

        // Back-to-back with req_valid held
        f0 = frames;
        @(negedge clk);
        req_write = 1'b1; req_addr = 7'd0; req_data = 8'h0F; req_valid = 1'b1;
        acc = cyc;
        chk("b2b_first_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_addr = 7'd1; req_data = 8'hF0;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_second_ready", req_ready, 1'b1);
        acc2 = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accept_spacing", acc2 - acc, 137);
        wait_ready(rdy);
        chk("b2b_frames", frames - f0, 2);
        chk("b2b_gap_ge5", (last_high >= 5), 1'b1);
        chk("b2b_word2", last_rx, 16'h81F0);
        chk("b2b_reg0", regs[0], 8'h0F);
        chk("b2b_reg1", regs[1], 8'hF0);

        // Reset after the 7th SCLK rise
        f0 = frames; d0 = done_cnt;
        @(negedge clk);
        req_write = 1'b1; req_addr = 7'd4; req_data = 8'h80; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (!(frames == f0 + 1 && rise_cnt == 7) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_rise7", rise_cnt, 7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ncs", nCS, 1'b1);
        chk("mid_rst_sclk", SCLK, 1'b0);
        chk("mid_rst_copi", COPI, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_reg4_kept", regs[4], 8'hA5);
        chk("mid_ready", req_ready, 1'b1);
        d0 = done_cnt;
        send(1'b1, 7'd4, 8'h80, acc);
        wait_ready(rdy);
        chk("post_rst_word", last_rx, 16'h8480);
        chk("post_rst_reg4", regs[4], 8'h80);
        chk("post_rst_done", done_cnt - d0, 1);

        // Closed loop: fill registers 0..4
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 7'(i), 8'(8'h11 * (i + 1)), acc);
            wait_ready(rdy);
        end
        chk("cl_done_count", done_cnt - d0, 5);
        chk("cl_reg0", regs[0], 8'h11);
        chk("cl_reg1", regs[1], 8'h22);
        chk("cl_reg2", regs[2], 8'h33);
        chk("cl_reg3", regs[3], 8'h44);
        chk("cl_reg4", regs[4], 8'h55);

        chk("copi_sclk_rules", viol, 0);
        chk("done_with_ncs_rise", done_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
